// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers a 32-bit big-endian word stream into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit bit length, and bursts each block as 16 words to the core.
module sha256_padder #(
    parameter int unsigned LEN_W = 61
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        in_ready,
    input  logic        sha_busy,
    output logic [31:0] data,
    output logic        write_enable,
    output logic        first_block,
    output logic        last_block,
    output logic        msg_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_WAIT,
        S_START,
        S_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      blk [16];
    logic [3:0]       idx_q;
    logic [3:0]       k_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [4:0]       pad_pos_q;   // word holding the 0x80 byte; 16 = deferred to next block
    logic             first_q;
    logic             final_q;
    logic             extra_q;
    logic             armed_q;
    logic             done_q;

    logic             xfer;
    logic [2:0]       add_bytes;
    logic [63:0]      bit_len;

    function automatic logic [31:0] pad_last(input logic [31:0] w, input logic [2:0] n);
        case (n)
            3'd0:    pad_last = 32'h8000_0000;
            3'd1:    pad_last = {w[31:24], 24'h80_0000};
            3'd2:    pad_last = {w[31:16], 16'h8000};
            3'd3:    pad_last = {w[31:8], 8'h80};
            default: pad_last = w;
        endcase
    endfunction

    assign xfer      = in_valid && in_ready;
    assign add_bytes = !in_last ? 3'd4 : (in_bytes[2] ? 3'd4 : in_bytes);
    assign bit_len   = 64'({byte_cnt_q, 3'b000});
    assign msg_done  = done_q;

    always_comb begin
        in_ready     = armed_q && (state_q == S_IDLE || state_q == S_FILL);
        write_enable = (state_q == S_SEND);
        data         = write_enable ? blk[k_q] : '0;
        first_block  = first_q && ((state_q == S_START) || (state_q == S_SEND && k_q == 4'd0));
        last_block   = final_q && (state_q == S_SEND) && (k_q == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (xfer) state_d = in_last ? S_PAD : S_FILL;
            S_FILL:  if (xfer) state_d = in_last ? S_PAD : ((idx_q == 4'd15) ? S_WAIT : S_FILL);
            S_PAD:   state_d = S_WAIT;
            S_WAIT:  if (!sha_busy) state_d = S_START;
            S_START: state_d = S_SEND;
            S_SEND:  if (k_q == 4'd15) state_d = final_q ? S_IDLE : (extra_q ? S_WAIT : S_FILL);
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < 16; j++) blk[j] <= '0;
            idx_q      <= '0;
            k_q        <= '0;
            byte_cnt_q <= '0;
            pad_pos_q  <= '0;
            first_q    <= 1'b0;
            final_q    <= 1'b0;
            extra_q    <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_FILL: begin
                    // words past the write index are already zero: the buffer is cleared at every block boundary
                    if (xfer) begin
                        if (in_last) begin
                            blk[idx_q] <= pad_last(in_data, in_bytes);
                            if (in_bytes[2] && idx_q != 4'd15) blk[idx_q + 4'd1] <= 32'h8000_0000;
                            pad_pos_q <= {1'b0, idx_q} + 5'(in_bytes[2]);
                        end else begin
                            blk[idx_q] <= in_data;
                        end
                        idx_q      <= idx_q + 4'd1;
                        byte_cnt_q <= ((state_q == S_IDLE) ? '0 : byte_cnt_q) + LEN_W'(add_bytes);
                        if (state_q == S_IDLE) first_q <= 1'b1;
                    end
                end
                S_PAD: begin
                    if (pad_pos_q <= 5'd13) begin
                        blk[14] <= bit_len[63:32];
                        blk[15] <= bit_len[31:0];
                        final_q <= 1'b1;
                    end else begin
                        extra_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    k_q <= k_q + 4'd1;
                    if (k_q == 4'd0) first_q <= 1'b0;
                    if (k_q == 4'd15) begin
                        for (int unsigned j = 0; j < 16; j++) blk[j] <= '0;
                        idx_q <= '0;
                        if (final_q) begin
                            final_q    <= 1'b0;
                            byte_cnt_q <= '0;
                            done_q     <= 1'b1;
                        end else if (extra_q) begin
                            blk[0]  <= pad_pos_q[4] ? 32'h8000_0000 : 32'h0;
                            blk[14] <= bit_len[63:32];
                            blk[15] <= bit_len[31:0];
                            final_q <= 1'b1;
                            extra_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: table of messages checked against a byte-level padding model,
// plus hand sequences for busy back-pressure and asynchronous reset mid-burst.
module tb_sha256_padder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [2:0]  in_bytes = '0;
    logic        in_ready;
    logic        sha_busy = 1'b0;
    logic [31:0] data;
    logic        write_enable;
    logic        first_block;
    logic        last_block;
    logic        msg_done;

    sha256_padder #(.LEN_W(61)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .in_ready     (in_ready),
        .sha_busy     (sha_busy),
        .data         (data),
        .write_enable (write_enable),
        .first_block  (first_block),
        .last_block   (last_block),
        .msg_done     (msg_done)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] got_w[$];
    logic [1:0]  got_f[$];
    logic [31:0] exp_w[$];
    int unsigned start_first = 0;
    int unsigned done_cnt = 0;
    int unsigned run_len = 0;
    int unsigned run_bad = 0;
    int unsigned idle_bad = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (write_enable) begin
                got_w.push_back(data);
                got_f.push_back({first_block, last_block});
                run_len++;
            end else begin
                if (run_len != 0 && run_len != 16) run_bad++;
                run_len = 0;
                if (data != 32'h0) idle_bad++;
                if (first_block) start_first++;
            end
            if (msg_done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_w.delete();
        got_f.delete();
        start_first = 0;
        done_cnt = 0;
        run_len = 0;
        run_bad = 0;
        idle_bad = 0;
    endtask

    task automatic build_model(input int unsigned n);
        logic [7:0]  mb[$];
        logic [63:0] bl;
        for (int unsigned i = 0; i < n; i++) mb.push_back(8'(8'h61 + i));
        mb.push_back(8'h80);
        while (mb.size() % 64 != 56) mb.push_back(8'h00);
        bl = 64'(n) * 64'd8;
        for (int b = 7; b >= 0; b--) mb.push_back(bl[b*8 +: 8]);
        exp_w.delete();
        for (int unsigned w = 0; w < mb.size() / 4; w++)
            exp_w.push_back({mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]});
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] nb);
        int unsigned t = 0;
        in_data = w; in_last = last; in_bytes = nb; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout got=0 expected=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
    endtask

    // words lo..hi-1 of an n-byte message; unused bytes of the last word are junk (0xAA)
    task automatic send_range(input int unsigned n, input int unsigned lo, input int unsigned hi);
        int unsigned nw;
        int unsigned nb;
        logic [31:0] w;
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int unsigned j = lo; j < hi; j++) begin
            nb = (j == nw - 1) ? n - 4*j : 4;
            for (int unsigned b = 0; b < 4; b++)
                w[31 - 8*b -: 8] = (b < nb) ? 8'(8'h61 + 4*j + b) : 8'hAA;
            send_word(w, j == nw - 1, 3'(nb));
        end
    endtask

    task automatic wait_done();
        int unsigned t = 0;
        while (done_cnt == 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL msg_done_timeout got=0 expected=1");
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_msg(input string tag, input int unsigned n, input int unsigned nblk,
                             input logic [31:0] w0, input logic [31:0] lenw);
        int unsigned nexp;
        logic [1:0]  ef;
        build_model(n);
        nexp = exp_w.size();
        chk($sformatf("%s word_count", tag), 64'(got_w.size()), 64'(16 * nblk));
        for (int unsigned i = 0; i < nexp; i++) begin
            ef = {(i == 0), (i == nexp - 16)};
            if (i < got_w.size()) begin
                chk($sformatf("%s word%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
                chk($sformatf("%s flags%0d", tag, i), 64'(got_f[i]), 64'(ef));
            end
        end
        if (got_w.size() > 0) begin
            chk($sformatf("%s first_word", tag), 64'(got_w[0]), 64'(w0));
            chk($sformatf("%s length_word", tag), 64'(got_w[got_w.size()-1]), 64'(lenw));
        end
        chk($sformatf("%s first_in_start", tag), 64'(start_first), 64'd1);
        chk($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'd1);
        chk($sformatf("%s burst_contiguous", tag), 64'(run_bad), 64'd0);
        chk($sformatf("%s idle_data_zero", tag), 64'(idle_bad), 64'd0);
    endtask

    typedef struct {
        int unsigned nbytes;
        int unsigned nblk;
        logic [31:0] w0;
        logic [31:0] lenw;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int unsigned viol;
        int unsigned seen;

        vecs[0] = '{3,   1, 32'h6162_6380, 32'h0000_0018};
        vecs[1] = '{0,   1, 32'h8000_0000, 32'h0000_0000};
        vecs[2] = '{56,  2, 32'h6162_6364, 32'h0000_01C0};
        vecs[3] = '{64,  2, 32'h6162_6364, 32'h0000_0200};
        vecs[4] = '{55,  1, 32'h6162_6364, 32'h0000_01B8};
        vecs[5] = '{60,  2, 32'h6162_6364, 32'h0000_01E0};
        vecs[6] = '{57,  2, 32'h6162_6364, 32'h0000_01C8};
        vecs[7] = '{120, 3, 32'h6162_6364, 32'h0000_03C0};
        vecs[8] = '{5,   1, 32'h6162_6364, 32'h0000_0028};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({data, write_enable, first_block, last_block, msg_done, in_ready}), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        for (int unsigned v = 0; v < 9; v++) begin
            clear_mon();
            send_range(vecs[v].nbytes, 0, (vecs[v].nbytes == 0) ? 1 : (vecs[v].nbytes + 3) / 4);
            wait_done();
            check_msg($sformatf("msg%0d_len%0d", v, vecs[v].nbytes), vecs[v].nbytes,
                      vecs[v].nblk, vecs[v].w0, vecs[v].lenw);
            @(posedge clk); #1;
        end

        // back-pressure: full buffer held while the core is busy
        clear_mon();
        sha_busy = 1'b1;
        send_range(80, 0, 16);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (write_enable || in_ready) viol++;
        end
        chk("busy_hold_quiet", 64'(viol), 64'd0);
        @(posedge clk); #1;
        sha_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_wait", 64'({write_enable, first_block}), 64'b00);
        @(negedge clk);
        chk("busy_release_start", 64'({write_enable, first_block}), 64'b01);
        @(negedge clk);
        chk("busy_release_send", 64'({write_enable, first_block}), 64'b11);
        send_range(80, 16, 20);
        wait_done();
        check_msg("busy_len80", 80, 2, 32'h6162_6364, 32'h0000_0280);

        // asynchronous reset while word 7 of a burst is on the bus
        @(posedge clk); #1;
        clear_mon();
        send_range(80, 0, 16);
        seen = 0;
        for (int i = 0; i < 100 && seen < 8; i++) begin
            @(negedge clk);
            if (write_enable) seen++;
        end
        chk("reset_hit_word7", 64'(seen), 64'd8);
        chk("word7_before_reset", 64'(data), 64'h6162_6364 + 64'h1C1C_1C1C);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({data, write_enable, first_block, last_block, msg_done, in_ready}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_midreset", 64'(in_ready), 64'd1);
        clear_mon();
        for (int i = 0; i < 40; i++) @(negedge clk);
        chk("no_output_after_reset", 64'(got_w.size() + done_cnt), 64'd0);

        @(posedge clk); #1;
        clear_mon();
        send_range(3, 0, 1);
        wait_done();
        check_msg("post_reset_abc", 3, 1, 32'h6162_6380, 32'h0000_0018);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream stage of the SHA-256 core: accepts an arbitrary-length byte message as a 32-bit word stream.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length.
- Buffers each 512-bit block and bursts it as 16 consecutive words into the core's data/write_enable/first_block/last_block interface.
- Holds each burst until the core deasserts busy.

Parameters:
LEN_W, 61, width of the internal byte counter (bit length = {byte_cnt,3'b000}, 64 bits max)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_data  input  32  message word, big-endian: byte 0 in [31:24]
in_valid  input  1  in_data valid
in_last  input  1  final word of message, qualified by in_valid
in_bytes  input  3  valid bytes in the final word, 0..4 (MSB-aligned); ignored unless in_last; non-last words always carry 4 bytes
in_ready  output  1  padder accepts a word this cycle (transfer = in_valid & in_ready)
sha_busy  input  1  core busy; no block starts while high
data  output  32  block word to core
write_enable  output  1  data valid
first_block  output  1  first block of message; asserted per core protocol (see below)
last_block  output  1  high with word 0 of the final block
msg_done  output  1  one-cycle pulse after the final block's word 15

Behaviour:
- Reset (reset=0, async): state IDLE, word index = 0, byte_cnt = 0, buffer cleared. data, write_enable, first_block, last_block, msg_done and in_ready are all 0. in_ready rises in the first cycle after reset releases.
- States:
  - IDLE: in_ready=1. First transfer writes buf[0], sets the first flag, and moves to FILL, or to PAD if in_last.
  - FILL: in_ready=1. Each transfer writes buf[idx], idx++, and byte_cnt += 4, or += in_bytes on the last word.
    - Transfer into idx 15 without in_last -> WAIT (more=1).
  - On the in_last transfer:
    - Mask the unused low bytes to 0 and insert 0x80 at byte in_bytes of that word.
    - If in_bytes=4, the 0x80 goes into byte 0 of the next word (next block if idx=15).
    - Zero all words after it. Go to PAD.
  - PAD (1 cycle, in_ready=0):
    - If the 0x80 byte lies in words 0..13, write words 14/15 = bit length [63:32]/[31:0] and set final=1.
    - Otherwise (0x80 in word 14 or 15, or deferred to the next block) set extra=1. The length goes into the following all-zero block.
  - WAIT: in_ready=0; stay while sha_busy=1; go to START when sha_busy=0.
  - START (1 cycle): write_enable=0; first_block=1 if the first flag is set.
  - SEND (16 cycles): write_enable=1, data=buf[k] for k=0..15, in consecutive cycles, never interrupted.
    - first_block=1 at k=0 if first flag; last_block=1 at k=0 if final; the first flag clears after k=0.
  - After k=15:
    - If final: pulse msg_done, go to IDLE.
    - Else if extra: load the zero block (or 0x80000000 in word 0 if deferred), add the length in words 14/15, set final, go to WAIT.
    - Else: clear the buffer and go to FILL.
- sha_busy is sampled only in WAIT; changes during SEND are ignored.
- Empty message (in_last with in_bytes=0 as the only word) produces one block: 0x80000000, 14 zero words, length 0.
- Words 0..15 of a block are always contiguous cycles; data=0 whenever write_enable=0.
- byte_cnt wraps modulo 2^LEN_W; no overflow flag.
- Reset mid-operation aborts immediately. Partial blocks are discarded; nothing is emitted after release until new input arrives.

Test Plan:
- "abc": in_data=0x61626300, in_bytes=3, in_last -> 16 words 0x61626380, 0x0 ×14, 0x00000018. first_block high in START and word0, last_block high in word0, msg_done pulse after word15.
- Empty message (in_bytes=0, in_last, data 0x0) -> word0=0x80000000, words 1..15 = 0. The core digest must then read e3b0c442...b855.
- 56-byte message (14 words, last in_bytes=4) -> block1 word14=0x80000000, word15=0, last_block=0. Block2 is all zeros except word15=0x000001C0, with last_block=1 at its word0 and first_block=0.
- 64-byte message -> block1 carries the 16 data words. Block2 has word0=0x80000000 and word15=0x00000200.
- Hold sha_busy=1 for 40 cycles after the buffer fills -> write_enable stays 0 and in_ready stays 0. START occurs 1 cycle after sha_busy falls, followed by the 16-word burst.
- Assert reset low at SEND word 7 -> all outputs 0 within the same cycle (async). After release, in_ready=1 and no write_enable occurs until new input arrives.
